// File: rtl/core_regfile_wb_arbiter.sv
// Write-port controller for the core register file: round-robin valid/ready arbitration
// between NREQ writeback requesters, registered rf_* stage. Optional CORE_REGFILE_CLEAR_EN adds a post-reset x1..x31 clear.
module core_regfile_wb_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*5-1:0]    req_addr,
    input  logic [NREQ*32-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [4:0]           rf_waddr,
    output logic [31:0]          rf_wdata,
    output logic                 rf_wen,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy
);

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic [IDW-1:0]  r_ptr;
    logic [AW-1:0]   r_waddr;
    logic [DW-1:0]   r_wdata;
    logic            r_wen;
    logic [IDW-1:0]  r_gid;

    logic            w_run;
    logic [NREQ-1:0] w_rot;
    logic            w_found;
    logic [IDW-1:0]  w_off;
    logic [IDW:0]    w_sum;
    logic [IDW-1:0]  w_gnt;
    logic [IDW-1:0]  w_next_ptr;
    logic            w_xfer;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_data;
    logic [NREQ-1:0] w_ready;

`ifdef CORE_REGFILE_CLEAR_EN
    typedef enum logic {ST_CLEAR, ST_RUN} state_t;
    state_t          r_state;
    logic [AW-1:0]   r_cnt;
    logic            r_busy;

    assign w_run = (r_state == ST_RUN);
    assign busy  = r_busy;
`else
    assign w_run = 1'b1;
    assign busy  = 1'b0;
`endif

    // Valid vector rotated so bit 0 is the requester at the round-robin pointer.
    assign w_rot = NREQ'({req_valid, req_valid} >> r_ptr);

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_found = 1'b1;
                w_off   = IDW'(i);
            end
        end
    end

    assign w_sum      = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_gnt      = (w_sum >= (IDW+1)'(NREQ)) ? IDW'(w_sum - (IDW+1)'(NREQ)) : w_sum[IDW-1:0];
    assign w_next_ptr = (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + IDW'(1);
    assign w_xfer     = w_run & rst & w_found;

    // Granted requester's payload and one-hot ready.
    always_comb begin
        w_addr  = '0;
        w_data  = '0;
        w_ready = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (w_gnt == IDW'(i)) begin
                w_addr     = req_addr[AW*i +: AW];
                w_data     = req_data[DW*i +: DW];
                w_ready[i] = w_xfer;
            end
        end
    end

    assign req_ready = w_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr   <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_wen   <= 1'b0;
            r_gid   <= '0;
`ifdef CORE_REGFILE_CLEAR_EN
            r_state <= ST_CLEAR;
            r_cnt   <= AW'(1);
            r_busy  <= 1'b1;
`endif
        end else begin
`ifdef CORE_REGFILE_CLEAR_EN
            if (r_state == ST_CLEAR) begin
                r_waddr <= r_cnt;
                r_wdata <= '0;
                r_wen   <= 1'b1;
                r_cnt   <= r_cnt + AW'(1);
                if (r_cnt == AW'(31)) begin
                    r_state <= ST_RUN;
                    r_busy  <= 1'b0;
                end
            end else
`endif
            if (w_xfer) begin
                r_waddr <= w_addr;
                r_wdata <= w_data;
                r_gid   <= w_gnt;
                r_wen   <= (w_addr != '0);
                r_ptr   <= w_next_ptr;
            end else begin
                r_wen   <= 1'b0;
            end
        end
    end

    assign rf_waddr = r_waddr;
    assign rf_wdata = r_wdata;
    assign rf_wen   = r_wen;
    assign grant_id = r_gid;

endmodule
